reg_hazard_scoreboard: RTL and testbench
========================================

Name: reg_hazard_scoreboard

Overview:
Scoreboard and hazard controller for the 32x32 register file in the 5-stage pipeline. It tracks every in-flight register write from ID issue through WB. For the instruction in ID it decides stall versus issue and selects the forwarding source for each operand. The register file read is registered, so a same-edge WB write is not visible to the ID read; this block covers that case with a WB bypass select.

Parameters:
NREG, 32, number of architectural registers; x0 is never tracked.
AW, 5, register index width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  AW  source 1 index
id_rs1_en  in  1  instruction reads rs1
id_rs2  in  AW  source 2 index
id_rs2_en  in  1  instruction reads rs2 (R/B/store)
id_rd  in  AW  destination index
id_rd_we  in  1  instruction writes rd (R/I/LW/U/JAL)
id_is_load  in  1  ID instruction is a load
flush  in  1  squash ID instruction (branch/jump taken)
pipe_hold  in  1  global pipeline freeze
wb_valid  in  1  WB writes the register file this cycle
wb_rd  in  AW  WB destination index
id_stall  out  1  hold IF/ID, inject bubble into EX
issue  out  1  ID instruction advances this cycle
fwd_a  out  2  operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB DIN bypass
fwd_b  out  2  operand B source, same encoding
busy_vec  out  NREG  per-register pending-write flags, bit 0 always 0
sb_err  out  1  sticky: an entry aged past WB without a write-back

Behaviour:
- Per-register state: busy, ld (producer is a load), age[1:0]. Age 0 = producer in EX, 1 = in MEM, 2 = in WB, 3 = overdue.
- Reset (async): all busy=0, ld=0, age=0, sb_err=0. Combinational outputs then give id_stall=0, fwd_a=fwd_b=00, busy_vec=0.
- Source check is combinational from current state. It applies only when srcN_en=1, the index is nonzero and busy=1:
  - age0, ld=0: fwd=01, no stall.
  - age0, ld=1: stall (load-use), fwd=00.
  - age1: fwd=10.
  - age2 or age3: fwd=11.
  - Not busy, index 0, or en=0: fwd=00.
- id_stall = id_valid & (load-use hazard on rs1 or rs2).
- issue = id_valid & ~id_stall & ~flush & ~pipe_hold.
- Aging at each clock edge when pipe_hold=0: every busy entry does age = age+1, saturating at 3. An entry entering age3 sets sb_err. sb_err is sticky until reset.
- pipe_hold=1: ages frozen, no issue. WB clears are still honoured.
- Issue allocation at the edge: if issue & id_rd_we & id_rd!=0, then entry[id_rd] gets busy=1, age=0, ld=id_is_load. This overwrites any older in-flight producer of the same rd (WAW; the newest producer wins).
- WB clear at the edge: if wb_valid & wb_rd!=0 & entry[wb_rd].age>=2, then busy=0. A WB clear with age<2 is a stale older writer and is ignored.
- Clear and allocate to the same index in one cycle: allocate wins (busy=1, age=0).
- flush: suppresses issue and allocation only. In-flight entries are untouched.
- Stall bubble: the bubble enters EX with no allocation. The stalled instruction re-evaluates next cycle; the load is then at age1 and fwd=10.
- Latency: the stall/forward decision is 0-cycle (combinational). State updates are 1-cycle.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.

Test Plan:
- ALU back-to-back: issue add x5; next cycle add x6,x5,x7 -> id_stall=0, fwd_a=01, fwd_b=00, busy_vec[5]=1.
- Load-use: issue lw x8; next cycle add x9,x8,x8 -> id_stall=1 for one cycle, then issue=1 with fwd_a=fwd_b=10.
- Distance 3: add x3; two independent instructions; consumer of x3 -> fwd=11. When wb_valid, wb_rd=3 arrives with age2 -> busy_vec[3]=0 next cycle.
- WAW: add x4 then lw x4 issued back-to-back. The first WB of x4 arrives while the entry is at age1 -> ignored, busy stays 1. The second WB clears it. A consumer one cycle after the lw stalls.
- x0 and flush: add x0 -> busy_vec stays 0, and a consumer of x0 gets fwd=00. Issue with flush=1 -> issue=0, no allocation.
- Reset mid-flight: three entries busy, assert rst between edges -> busy_vec=0 and id_stall=0 at once. sb_err is set only if a WB is withheld for 3 cycles after issue.

Source files
------------

// File: rtl/reg_hazard_scoreboard.sv
// Register scoreboard for the 5-stage pipeline: tracks in-flight writes,
// resolves load-use stalls and selects operand forwarding sources.
module reg_hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic            id_rs1_en,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs2_en,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic            pipe_hold,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic            id_stall,
    output logic            issue,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [NREG-1:0] busy_vec,
    output logic            sb_err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] ld_q, ld_d;
    logic [1:0]      age_q [NREG];
    logic [1:0]      age_d [NREG];
    logic            sb_err_q, sb_err_d;

    logic [2:0]      chk_a, chk_b;
    logic            alloc;

    // Returns {load_use, fwd[1:0]} for one source operand.
    function automatic logic [2:0] src_check(input logic en, input logic [AW-1:0] idx);
        logic [2:0] r;
        r = '0;
        if (en && (idx != '0) && busy_q[idx]) begin
            case (age_q[idx])
                2'd0:    r = ld_q[idx] ? 3'b100 : 3'b001;
                2'd1:    r = 3'b010;
                default: r = 3'b011;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        chk_a    = src_check(id_rs1_en, id_rs1);
        chk_b    = src_check(id_rs2_en, id_rs2);
        fwd_a    = chk_a[1:0];
        fwd_b    = chk_b[1:0];
        id_stall = id_valid & (chk_a[2] | chk_b[2]);
        issue    = id_valid & ~id_stall & ~flush & ~pipe_hold;
        alloc    = issue & id_rd_we & (id_rd != '0);
        busy_vec = busy_q;
        sb_err   = sb_err_q;
    end

    // Per entry: age first, then WB clear, then allocation (allocation wins).
    always_comb begin
        busy_d   = busy_q;
        ld_d     = ld_q;
        sb_err_d = sb_err_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            age_d[i] = age_q[i];
        end
        for (int unsigned i = 1; i < NREG; i++) begin
            logic wb_hit;
            wb_hit = wb_valid && (wb_rd == AW'(i)) && (age_q[i] >= 2'd2);
            if (busy_q[i] && !pipe_hold && (age_q[i] != 2'd3)) begin
                age_d[i] = age_q[i] + 2'd1;
                if ((age_q[i] == 2'd2) && !wb_hit) begin
                    sb_err_d = 1'b1;
                end
            end
            if (busy_q[i] && wb_hit) begin
                busy_d[i] = 1'b0;
            end
            if (alloc && (id_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
                age_d[i]  = 2'd0;
                ld_d[i]   = id_is_load;
            end
        end
        busy_d[0] = 1'b0;
        ld_d[0]   = 1'b0;
        age_d[0]  = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            ld_q     <= '0;
            sb_err_q <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            ld_q     <= ld_d;
            sb_err_q <= sb_err_d;
            for (int unsigned i = 0; i < NREG; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed self-checking bench for reg_hazard_scoreboard.
module tb_reg_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_en;
    logic [4:0]  id_rs2;
    logic        id_rs2_en;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic        flush;
    logic        pipe_hold;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        id_stall;
    logic        issue;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] busy_vec;
    logic        sb_err;

    int total = 0;
    int passed = 0;

    reg_hazard_scoreboard #(.NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
        .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
        .pipe_hold(pipe_hold), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .id_stall(id_stall), .issue(issue), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs1_en = 0; id_rs2 = 0; id_rs2_en = 0;
        id_rd = 0; id_rd_we = 0; id_is_load = 0; flush = 0; pipe_hold = 0;
        wb_valid = 0; wb_rd = 0;
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic rs1_en,
                          input logic [4:0] rs2, input logic rs2_en,
                          input logic [4:0] rd, input logic rd_we, input logic is_load);
        id_valid = 1; id_rs1 = rs1; id_rs1_en = rs1_en; id_rs2 = rs2; id_rs2_en = rs2_en;
        id_rd = rd; id_rd_we = rd_we; id_is_load = is_load;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        #3;
        total++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", id_stall); else passed++;
        total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", sb_err); else passed++;
        rst = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        total++; if (issue !== 1'b1) $display("FAIL b2b_issue got=%b exp=1", issue); else passed++;
        tick();
        set_id(5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
        total++; if (id_stall !== 1'b0) $display("FAIL b2b_stall got=%b exp=0", id_stall); else passed++;
        total++; if (fwd_a !== 2'b01) $display("FAIL b2b_fwd_a got=%b exp=01", fwd_a); else passed++;
        total++; if (fwd_b !== 2'b00) $display("FAIL b2b_fwd_b got=%b exp=00", fwd_b); else passed++;
        total++; if (busy_vec[5] !== 1'b1) $display("FAIL b2b_busy5 got=%b exp=1", busy_vec[5]); else passed++;
        tick();
        idle_inputs();
        total++; if (busy_vec !== 32'h0000_0060) $display("FAIL b2b_busyvec got=%h exp=%h", busy_vec, 32'h60); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd0, 0, 5'd0, 0, 5'd8, 1, 1);
        tick();
        set_id(5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
        total++; if (id_stall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", id_stall); else passed++;
        total++; if (issue !== 1'b0) $display("FAIL lu_issue0 got=%b exp=0", issue); else passed++;
        total++; if (fwd_a !== 2'b00) $display("FAIL lu_fwd_a0 got=%b exp=00", fwd_a); else passed++;
        tick();
        total++; if (id_stall !== 1'b0) $display("FAIL lu_stall2 got=%b exp=0", id_stall); else passed++;
        total++; if (issue !== 1'b1) $display("FAIL lu_issue1 got=%b exp=1", issue); else passed++;
        total++; if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL lu_fwd got=%b exp=1010", {fwd_a, fwd_b}); else passed++;
        total++; if (busy_vec[9] !== 1'b0) $display("FAIL lu_no_alloc got=%b exp=0", busy_vec[9]); else passed++;
        tick();
        idle_inputs();
        total++; if (busy_vec[9] !== 1'b1) $display("FAIL lu_alloc9 got=%b exp=1", busy_vec[9]); else passed++;
    endtask

    task automatic test_distance3();
        do_reset();
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        tick();
        set_id(5'd1, 1, 5'd0, 0, 5'd10, 1, 0);
        tick();
        set_id(5'd2, 1, 5'd0, 0, 5'd11, 1, 0);
        tick();
        set_id(5'd3, 1, 5'd3, 1, 5'd12, 1, 0);
        wb_valid = 1; wb_rd = 5'd3;
        #1;
        total++; if ({fwd_a, fwd_b} !== 4'b1111) $display("FAIL d3_fwd got=%b exp=1111", {fwd_a, fwd_b}); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL d3_stall got=%b exp=0", id_stall); else passed++;
        tick();
        idle_inputs();
        total++; if (busy_vec !== 32'h0000_1C00) $display("FAIL d3_busyvec got=%h exp=%h", busy_vec, 32'h1C00); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL d3_err got=%b exp=0", sb_err); else passed++;
    endtask

    task automatic test_waw();
        do_reset();
        set_id(5'd1, 1, 5'd2, 1, 5'd4, 1, 0);
        tick();
        set_id(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
        total++; if (issue !== 1'b1) $display("FAIL waw_lw_issue got=%b exp=1", issue); else passed++;
        tick();
        set_id(5'd4, 1, 5'd0, 0, 5'd0, 0, 0);
        total++; if (id_stall !== 1'b1) $display("FAIL waw_stall got=%b exp=1", id_stall); else passed++;
        total++; if (fwd_a !== 2'b00) $display("FAIL waw_fwd got=%b exp=00", fwd_a); else passed++;
        idle_inputs();
        tick();
        wb_valid = 1; wb_rd = 5'd4;
        tick();
        total++; if (busy_vec[4] !== 1'b1) $display("FAIL waw_stale_wb got=%b exp=1", busy_vec[4]); else passed++;
        tick();
        idle_inputs();
        total++; if (busy_vec[4] !== 1'b0) $display("FAIL waw_clear got=%b exp=0", busy_vec[4]); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL waw_err got=%b exp=0", sb_err); else passed++;
    endtask

    task automatic test_x0_flush_hold();
        do_reset();
        set_id(5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        total++; if (issue !== 1'b1) $display("FAIL x0_issue got=%b exp=1", issue); else passed++;
        tick();
        set_id(5'd0, 1, 5'd0, 1, 5'd13, 1, 0);
        total++; if (busy_vec !== 32'h0) $display("FAIL x0_busy got=%h exp=0", busy_vec); else passed++;
        total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL x0_fwd got=%b exp=0000", {fwd_a, fwd_b}); else passed++;
        flush = 1;
        #1;
        total++; if (issue !== 1'b0) $display("FAIL flush_issue got=%b exp=0", issue); else passed++;
        tick();
        idle_inputs();
        total++; if (busy_vec[13] !== 1'b0) $display("FAIL flush_alloc got=%b exp=0", busy_vec[13]); else passed++;
        set_id(5'd0, 0, 5'd0, 0, 5'd14, 1, 0);
        tick();
        set_id(5'd14, 1, 5'd0, 0, 5'd15, 1, 0);
        pipe_hold = 1;
        #1;
        tick();
        tick();
        total++; if (fwd_a !== 2'b01) $display("FAIL hold_age got=%b exp=01", fwd_a); else passed++;
        total++; if (issue !== 1'b0) $display("FAIL hold_issue got=%b exp=0", issue); else passed++;
        total++; if (busy_vec !== 32'h0000_4000) $display("FAIL hold_busy got=%h exp=%h", busy_vec, 32'h4000); else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_id(5'd0, 0, 5'd0, 0, 5'd1, 1, 0);
        tick();
        set_id(5'd0, 0, 5'd0, 0, 5'd2, 1, 0);
        tick();
        set_id(5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        set_id(5'd3, 1, 5'd1, 1, 5'd6, 1, 0);
        total++; if (busy_vec !== 32'h0000_000E) $display("FAIL mid_busy got=%h exp=%h", busy_vec, 32'hE); else passed++;
        total++; if (id_stall !== 1'b1) $display("FAIL mid_stall got=%b exp=1", id_stall); else passed++;
        total++; if (fwd_b !== 2'b11) $display("FAIL mid_fwd_b got=%b exp=11", fwd_b); else passed++;
        rst = 1;
        #1;
        total++; if (busy_vec !== 32'h0) $display("FAIL mid_rst_busy got=%h exp=0", busy_vec); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL mid_rst_stall got=%b exp=0", id_stall); else passed++;
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_sb_err();
        do_reset();
        set_id(5'd0, 0, 5'd0, 0, 5'd20, 1, 0);
        tick();
        idle_inputs();
        tick();
        tick();
        total++; if (sb_err !== 1'b0) $display("FAIL err_early got=%b exp=0", sb_err); else passed++;
        tick();
        total++; if (sb_err !== 1'b1) $display("FAIL err_set got=%b exp=1", sb_err); else passed++;
        wb_valid = 1; wb_rd = 5'd20;
        tick();
        idle_inputs();
        total++; if (sb_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", sb_err); else passed++;
        total++; if (busy_vec[20] !== 1'b0) $display("FAIL err_late_wb got=%b exp=0", busy_vec[20]); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_distance3();
        test_waw();
        test_x0_flush_hold();
        test_reset_midflight();
        test_sb_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
